// File: rtl/bytes_to_bits_if.sv
// Handshake bundle between a byte producer and bytes_to_bits.
// The master drives bytes and length; the slave returns the registered bit vector.
interface bytes_to_bits_if #(
  parameter int BYTE_COUNT = 128
);
  localparam int LEN_W = $clog2(BYTE_COUNT - 1) + 1;

  logic                    in_valid;
  logic [7:0]              B [BYTE_COUNT-1:0];
  logic [LEN_W-1:0]        len;
  logic [8*BYTE_COUNT-1:0] b;
  logic                    out_valid;

  modport master (
    output in_valid,
    output B,
    output len,
    input  b,
    input  out_valid
  );

  modport slave (
    input  in_valid,
    input  B,
    input  len,
    output b,
    output out_valid
  );
endinterface

// File: rtl/bytes_to_bits.sv
// Registered Kyber BytesToBits: unpacks bytes LSB-first into a flat vector,
// zeroing every byte at or beyond the clamped length. One-cycle latency, no backpressure.
module bytes_to_bits #(
  parameter int BYTE_COUNT = 128
) (
  input  logic            clk,
  input  logic            reset,
  bytes_to_bits_if.slave  bus
);
  localparam int LEN_W = $clog2(BYTE_COUNT - 1) + 1;
  localparam int BIT_W = 8 * BYTE_COUNT;

  logic [LEN_W-1:0]      eff_len;
  logic [BYTE_COUNT-1:0] byte_en;
  logic [BIT_W-1:0]      b_next;
  logic [BIT_W-1:0]      b_q;
  logic                  valid_q;

  // Clamp the requested length, then build the per-byte enable by direct compare
  always_comb begin
    eff_len = bus.len;
    if (bus.len > LEN_W'(BYTE_COUNT)) begin
      eff_len = LEN_W'(BYTE_COUNT);
    end
    byte_en = '0;
    for (int i = 0; i < BYTE_COUNT; i++) begin
      byte_en[i] = (LEN_W'(i) < eff_len);
    end
  end

  always_comb begin
    b_next = '0;
    for (int i = 0; i < BYTE_COUNT; i++) begin
      if (byte_en[i]) begin
        b_next[8*i +: 8] = bus.B[i];
      end
    end
  end

  // The vector holds between captures; only out_valid drops when in_valid is low
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      b_q     <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= bus.in_valid;
      if (bus.in_valid) begin
        b_q <= b_next;
      end
    end
  end

  assign bus.b         = b_q;
  assign bus.out_valid = valid_q;
endmodule

// File: tb/tb_bytes_to_bits.sv
// Randomised and directed bench for bytes_to_bits against a per-bit arithmetic model.
module tb_bytes_to_bits;
  localparam int BC    = 128;
  localparam int W     = 8 * BC;
  localparam int LEN_W = $clog2(BC - 1) + 1;

  logic clk;
  logic reset;

  bytes_to_bits_if #(.BYTE_COUNT(BC)) bus ();

  bytes_to_bits #(.BYTE_COUNT(BC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [7:0]   stim_bytes [BC];
  logic [W-1:0] exp_b;
  logic         exp_v;
  logic [W-1:0] const_b;
  int           checks;
  int           errors;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: each output bit k comes from byte k/8, bit k%8, if that byte is inside the clamped length
  function automatic logic [W-1:0] modelBits(input int len_v);
    logic [W-1:0] r;
    int eff;
    eff = (len_v < BC) ? len_v : BC;
    r = '0;
    for (int k = 0; k < W; k++) begin
      if ((k / 8) < eff) begin
        r[k] = (stim_bytes[k / 8] >> (k % 8)) & 8'd1;
      end
    end
    return r;
  endfunction

  task automatic checkOutput(input string tag, input logic [W-1:0] observed, input logic [W-1:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h want %h", tag, observed, expected);
    end
  endtask

  task automatic fillBytes(input logic [7:0] value);
    for (int i = 0; i < BC; i++) stim_bytes[i] = value;
  endtask

  task automatic randomBytes();
    for (int i = 0; i < BC; i++) stim_bytes[i] = 8'($urandom);
  endtask

  // Drive one cycle of inputs, advance past the edge, then compare against the model
  task automatic applyStimulus(input string tag, input bit valid, input int len_v);
    bus.in_valid = valid;
    bus.len      = LEN_W'(len_v);
    for (int i = 0; i < BC; i++) bus.B[i] = stim_bytes[i];
    @(posedge clk);
    #1;
    if (valid) begin
      exp_b = modelBits(len_v);
      exp_v = 1'b1;
    end else begin
      exp_v = 1'b0;
    end
    checkOutput({tag, "_b"}, bus.b, exp_b);
    checkOutput({tag, "_valid"}, W'(bus.out_valid), W'(exp_v));
  endtask

  initial begin
    checks = 0;
    errors = 0;
    exp_b  = '0;
    exp_v  = 1'b0;

    reset = 1'b0;
    randomBytes();
    bus.in_valid = 1'b1;
    bus.len      = LEN_W'(128);
    for (int i = 0; i < BC; i++) bus.B[i] = stim_bytes[i];
    #1;
    checkOutput("reset_async_b", bus.b, '0);
    checkOutput("reset_async_valid", W'(bus.out_valid), '0);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      checkOutput("reset_hold_b", bus.b, '0);
      checkOutput("reset_hold_valid", W'(bus.out_valid), '0);
    end

    reset = 1'b1;
    applyStimulus("first_capture", 1'b1, 128);

    fillBytes(8'h00);
    stim_bytes[0] = 8'h01;
    stim_bytes[1] = 8'h80;
    applyStimulus("bit_order", 1'b1, 128);
    const_b = '0;
    const_b[0]  = 1'b1;
    const_b[15] = 1'b1;
    checkOutput("bit_order_const", bus.b, const_b);

    fillBytes(8'hA5);
    applyStimulus("full_a5", 1'b1, 128);
    checkOutput("full_a5_const", bus.b, {BC{8'hA5}});

    fillBytes(8'hFF);
    applyStimulus("len1", 1'b1, 1);
    checkOutput("len1_const", bus.b, W'(8'hFF));
    applyStimulus("len0", 1'b1, 0);
    checkOutput("len0_const", bus.b, '0);
    applyStimulus("len127", 1'b1, 127);
    checkOutput("len127_const", bus.b, {8'h00, {(W-8){1'b1}}});
    applyStimulus("len200", 1'b1, 200);
    checkOutput("len200_const", bus.b, {W{1'b1}});
    applyStimulus("len255", 1'b1, 255);

    fillBytes(8'h00);
    for (int s = 1; s <= 3; s++) begin
      stim_bytes[0] = 8'(s);
      applyStimulus("stream", 1'b1, 128);
      checkOutput("stream_byte0", W'(bus.b[7:0]), W'(s));
    end
    applyStimulus("stream_idle", 1'b0, 128);
    checkOutput("stream_hold_byte0", W'(bus.b[7:0]), W'(3));

    fillBytes(8'hFF);
    applyStimulus("pre_midreset", 1'b1, 128);
    #2;
    reset = 1'b0;
    #1;
    checkOutput("midreset_async_b", bus.b, '0);
    checkOutput("midreset_async_valid", W'(bus.out_valid), '0);
    @(posedge clk);
    #1;
    checkOutput("midreset_edge_b", bus.b, '0);
    checkOutput("midreset_edge_valid", W'(bus.out_valid), '0);
    reset = 1'b1;
    exp_b = '0;
    applyStimulus("post_midreset_idle", 1'b0, 128);

    for (int n = 0; n < 300; n++) begin
      randomBytes();
      applyStimulus("random", ($urandom_range(0, 9) < 7), int'($urandom_range(0, 255)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/bytes_to_bits.md
# bytes_to_bits

Registered byte-array to bit-vector converter for the Kyber sampling path. It unpacks up to `BYTE_COUNT` bytes into a flat little-endian bit vector (bit `j` of byte `i` becomes bit `8*i+j`). Bytes at or beyond the requested length are forced to zero. It feeds the centred-binomial sampler (CBD), which reads bit pairs from the vector.

## Interface
Parameters:
- `BYTE_COUNT`, default 128: number of input bytes; the output is `8*BYTE_COUNT` bits wide.
- `LEN_W`, default `$clog2(BYTE_COUNT-1)+1` (8 for 128): width of `len`. It is derived and must not be overridden.

Ports:
- `clk`  input  1  single clock; all state updates on the rising edge.
- `reset`  input  1  asynchronous, active-low reset.
- `in_valid`  input  1  qualifies `B`/`len` for capture this cycle.
- `B`  input  unpacked array `[BYTE_COUNT-1:0]` of `[7:0]`  input bytes; `B[0]` is the first byte.
- `len`  input  `LEN_W`  number of valid bytes, counted from `B[0]`.
- `b`  output  `8*BYTE_COUNT`  registered unpacked bit vector.
- `out_valid`  output  1  high for one cycle when `b` holds a new result.

## Operation
- Effective length: `L = min(len, BYTE_COUNT)`. Any `len` above `BYTE_COUNT` clamps to `BYTE_COUNT`.
- Bit mapping, for every i in 0..BYTE_COUNT-1 and j in 0..7: `b_next[8*i+j] = (i < L) ? B[i][j] : 0`.
- Mapping is LSB-first within each byte (Kyber BytesToBits): `b[0]` = `B[0][0]`, `b[7]` = `B[0][7]`, `b[8]` = `B[1][0]`.
- `len = 0` produces an all-zero result. `out_valid` still asserts.
- No arithmetic; the block is pure bit routing plus a per-byte enable mask.
- Mask generation is a per-byte compare `i < L`. Do not use a variable shift wider than `LEN_W+3` bits.
- Capture happens on a rising edge where `in_valid` = 1: `b <= b_next`, `out_valid <= 1`.
- On a rising edge where `in_valid` = 0: `b` holds its previous value and `out_valid <= 0`.
- Back-to-back `in_valid` cycles are accepted every cycle. There is no backpressure and no ready signal.

## Timing
- Latency: 1 cycle. Inputs sampled at edge N appear on `b` with `out_valid` = 1 after edge N.
- Throughput: one conversion per cycle.
- Reset asserted (`reset` = 0), asynchronous: `b` = 0 and `out_valid` = 0 immediately, independent of `clk`.
- Reset release is synchronous to the next edge. The first capture can occur on the first rising edge after `reset` = 1.
- Reset mid-stream: any capture in flight is discarded; `out_valid` stays 0 until a new `in_valid` capture.
- `B` and `len` only need to be stable around the rising edge where `in_valid` = 1. They are don't-care otherwise.
- There is no combinational path from inputs to outputs.

## Test plan
- **Reset:** hold `reset` = 0 with random `B`, `len` = 128, `in_valid` = 1 -> `b` = 0 and `out_valid` = 0 throughout. Release reset -> valid data one cycle after the first capture edge.
- **Bit order:** `B[0]` = 8'h01, `B[1]` = 8'h80, all others 0, `len` = 128 -> after one edge `b[0]` = 1, `b[15]` = 1, every other bit 0, `out_valid` = 1 for one cycle.
- **Full pattern:** `B[i]` = 8'hA5 for all i, `len` = 128 -> `b` = {128{8'hA5}}, i.e. `b[8*i +: 8]` = 8'hA5 for every i.
- **Length masking:** `B[i]` = 8'hFF for all i, with `len` = 1 -> only `b[7:0]` = 8'hFF; with `len` = 0 -> `b` = 0; with `len` = 127 -> `b[1023:1016]` = 0 and the rest ones; with `len` = 200 -> all 1024 bits = 1 (clamped).
- **Hold and streaming:** three consecutive `in_valid` cycles with `B[0]` = 1, 2, 3 -> `b[7:0]` = 1, 2, 3 on successive cycles with `out_valid` high for all three. Then `in_valid` = 0 -> `b[7:0]` stays 3 and `out_valid` = 0.
- **Reset mid-operation:** capture 8'hFF patterns, then pulse `reset` low between edges -> `b` = 0 and `out_valid` = 0 immediately, before the next clock edge.
